rv32_instruction_encoder: RTL and testbench
===========================================

# rv32_instruction_encoder

Streaming RV32I instruction encoder: the inverse of the instruction decoder. Accepts one operation index plus register/immediate fields per handshake, packs them into a 32-bit instruction word, and emits it with a word address for writing into instruction memory. Used by the program loader and self-test sequencer to build instruction images on-chip. Malformed requests are consumed, produce no output, and set a sticky error.

## Interface
- ADDR_W, 12: width of instruction-memory byte address
- BASE_ADDR, 0: first emitted address, word aligned
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- in_op  in  5  operation index 0..22, decoder flag order: 0 and, 1 or, 2 xor, 3 sltu, 4 slt, 5 sll, 6 sub, 7 add, 8 srai, 9 srli, 10 slli, 11 andi, 12 ori, 13 xori, 14 sltiu, 15 slti, 16 addi, 17 beq, 18 bge, 19 bgeu, 20 blt, 21 bltu, 22 bne
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_imm  in  13  signed immediate: I-type uses [11:0], shift amount uses full value, branch offset uses [12:0]
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_word
- err  out  1  sticky malformed-request flag
- err_count  out  8  malformed requests, saturating at 255
- word_count  out  16  words emitted, wrapping

## Operation
- Request handshake: in_valid && in_ready. Response handshake: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a single output register that accepts a new request in the same cycle the held word drains.
- Field packing uses standard RV32I formats:
  - R-type: opcode 0110011; funct7 0100000 for sub, 0000000 otherwise.
  - I-type ALU: opcode 0010011. slli/srli/srai place in_imm[4:0] in [24:20], with funct7 0100000 for srai and 0000000 otherwise.
  - Branch: opcode 1100011, B-immediate scrambled from in_imm[12:1].
- Fields that a format does not use are ignored: rs2 for I-type, rd for branches.
- Malformed request, which is accepted but not emitted:
  - in_op > 22;
  - shift op with in_imm > 31 or < 0;
  - I-type ALU op with in_imm[12] != in_imm[11], i.e. the immediate does not fit in 12 bits signed;
  - branch with in_imm[0] = 1.
- On a malformed request: err is set, err_count increments, and out_valid/out_word are unchanged.
- Address: out_addr starts at BASE_ADDR. It increments by 4 on each response handshake and wraps modulo 2^ADDR_W.
- word_count increments on each response handshake.

## Timing
- Latency is 1 cycle: a request accepted at edge N gives out_valid high after edge N.
- A word remains stable while out_valid && !out_ready.
- When a request and a response handshake occur in the same cycle, the register loads the new word, out_valid stays 1, and the address advances once.
- When a malformed request and a response handshake occur in the same cycle, out_valid falls to 0.
- Reset values: in_ready 1 (it follows the combinational rule), out_valid 0, out_word 0, out_addr BASE_ADDR, err 0, err_count 0, word_count 0.
- Reset asserted mid-stream drops the held word without a response handshake and restarts addressing at BASE_ADDR.
- There is no FSM beyond the valid bit: the states are EMPTY (out_valid = 0) and FULL (out_valid = 1).

## Structure
- Package rv32_isa_pkg holds:
  - the op index enum (shared with the decoder flag ordering);
  - opcode constants OPC_OP, OPC_OPIMM, OPC_BRANCH;
  - funct3/funct7 constants;
  - the opcode, funct3 and funct7 field widths.
- Sub-module rv32_field_pack is the combinational format packer plus legality check, with outputs word[31:0] and bad. It is instantiated once. The top level holds the output register, counters and handshake.

## Test plan
- addi: op 16, rd 1, rs1 0, imm 5 -> out_word 0x00500093 at out_addr 0x000 one cycle later.
- sub: op 6, rd 3, rs1 1, rs2 2 -> 0x402081B3. Then srai, op 8, rd 5, rs1 6, imm 3 -> 0x40335293 at 0x004; word_count 2.
- beq: op 17, rs1 1, rs2 2, imm 8 -> 0x00208463. bne with imm -4 -> 0xFE209EE3.
- Backpressure: hold out_ready low 3 cycles with in_valid high. out_word stays constant, in_ready is 0, and no address advance occurs. When out_ready rises, the next word loads in the same cycle.
- Malformed requests: op 23 -> no out_valid, err 1, err_count 1. Then slli with imm 32 -> err_count 2. Then branch with imm 3 -> err_count 3. A following valid addi still emits normally at the next address.
- rst_n low for 1 cycle while out_valid = 1 and out_addr 0x010 -> out_valid 0, out_addr BASE_ADDR, and counters 0 on the next cycle. Wraparound: with ADDR_W 4, the 5th word lands at address 0x0.

Source files
------------

// File: rtl/rv32_isa_pkg.sv
// RV32I encoding constants shared by the encoder and the decoder flag ordering.
// Latency: n/a (types, constants and a pure packing helper).
// Backpressure: n/a.
package rv32_isa_pkg;

  localparam int OPC_W = 7;
  localparam int F3_W  = 3;
  localparam int F7_W  = 7;

  // Operation index, in the same order as the decoder's flag vector.
  typedef enum logic [4:0] {
    OP_AND   = 5'd0,
    OP_OR    = 5'd1,
    OP_XOR   = 5'd2,
    OP_SLTU  = 5'd3,
    OP_SLT   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SUB   = 5'd6,
    OP_ADD   = 5'd7,
    OP_SRAI  = 5'd8,
    OP_SRLI  = 5'd9,
    OP_SLLI  = 5'd10,
    OP_ANDI  = 5'd11,
    OP_ORI   = 5'd12,
    OP_XORI  = 5'd13,
    OP_SLTIU = 5'd14,
    OP_SLTI  = 5'd15,
    OP_ADDI  = 5'd16,
    OP_BEQ   = 5'd17,
    OP_BGE   = 5'd18,
    OP_BGEU  = 5'd19,
    OP_BLT   = 5'd20,
    OP_BLTU  = 5'd21,
    OP_BNE   = 5'd22
  } op_t;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU    = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [F3_W-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [F3_W-1:0] F3_OR      = 3'b110;
  localparam logic [F3_W-1:0] F3_AND     = 3'b111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  // Which field layout an op uses; FMT_BAD marks an unknown op index.
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_SH  = 3'd1,
    FMT_I   = 3'd2,
    FMT_B   = 3'd3,
    FMT_BAD = 3'd4
  } fmt_t;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // R-type bit layout. Shifts and branches reuse it by passing their
  // immediate slices in the funct7/rs2/rd slots.
  function automatic logic [31:0] pack_r(input logic [F7_W-1:0] f7,
                                         input logic [4:0] rs2,
                                         input logic [4:0] rs1,
                                         input logic [F3_W-1:0] f3,
                                         input logic [4:0] rd,
                                         input logic [OPC_W-1:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

endpackage

// File: rtl/rv32_field_pack.sv
// Combinational RV32I format packer with request legality check.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when word/bad are used.
module rv32_field_pack
  import rv32_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  fmt_t            fmt;
  logic [F3_W-1:0] f3;
  logic [F7_W-1:0] f7;

  // Decode the op index into a format plus funct3/funct7.
  always_comb begin
    fmt = FMT_BAD;
    f3  = '0;
    f7  = F7_BASE;
    case (op_t'(op))
      OP_AND:   begin fmt = FMT_R;  f3 = F3_AND;     end
      OP_OR:    begin fmt = FMT_R;  f3 = F3_OR;      end
      OP_XOR:   begin fmt = FMT_R;  f3 = F3_XOR;     end
      OP_SLTU:  begin fmt = FMT_R;  f3 = F3_SLTU;    end
      OP_SLT:   begin fmt = FMT_R;  f3 = F3_SLT;     end
      OP_SLL:   begin fmt = FMT_R;  f3 = F3_SLL;     end
      OP_SUB:   begin fmt = FMT_R;  f3 = F3_ADD_SUB; f7 = F7_ALT; end
      OP_ADD:   begin fmt = FMT_R;  f3 = F3_ADD_SUB; end
      OP_SRAI:  begin fmt = FMT_SH; f3 = F3_SRL_SRA; f7 = F7_ALT; end
      OP_SRLI:  begin fmt = FMT_SH; f3 = F3_SRL_SRA; end
      OP_SLLI:  begin fmt = FMT_SH; f3 = F3_SLL;     end
      OP_ANDI:  begin fmt = FMT_I;  f3 = F3_AND;     end
      OP_ORI:   begin fmt = FMT_I;  f3 = F3_OR;      end
      OP_XORI:  begin fmt = FMT_I;  f3 = F3_XOR;     end
      OP_SLTIU: begin fmt = FMT_I;  f3 = F3_SLTU;    end
      OP_SLTI:  begin fmt = FMT_I;  f3 = F3_SLT;     end
      OP_ADDI:  begin fmt = FMT_I;  f3 = F3_ADD_SUB; end
      OP_BEQ:   begin fmt = FMT_B;  f3 = F3_BEQ;     end
      OP_BGE:   begin fmt = FMT_B;  f3 = F3_BGE;     end
      OP_BGEU:  begin fmt = FMT_B;  f3 = F3_BGEU;    end
      OP_BLT:   begin fmt = FMT_B;  f3 = F3_BLT;     end
      OP_BLTU:  begin fmt = FMT_B;  f3 = F3_BLTU;    end
      OP_BNE:   begin fmt = FMT_B;  f3 = F3_BNE;     end
      default:  begin fmt = FMT_BAD; end
    endcase
  end

  // Pack fields for the selected format and flag immediates that do not fit.
  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (fmt)
      FMT_R: begin
        word = pack_r(f7, rs2, rs1, f3, rd, OPC_OP);
      end
      FMT_SH: begin
        // Shift amount must be 0..31; any set bit above [4] is out of range,
        // including the sign bit of a negative value.
        bad  = (imm[12:5] != 8'd0);
        word = pack_r(f7, imm[4:0], rs1, f3, rd, OPC_OPIMM);
      end
      FMT_I: begin
        // 13-bit input must sign-extend cleanly from bit 11.
        bad  = (imm[12] != imm[11]);
        word = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
      end
      FMT_B: begin
        // Branch targets are halfword aligned; bit 0 is not encodable.
        bad  = imm[0];
        word = pack_r({imm[12], imm[10:5]}, rs2, rs1, f3,
                      {imm[4:1], imm[11]}, OPC_BRANCH);
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32_instruction_encoder.sv
// Streaming RV32I encoder: request fields in, packed word plus byte address out.
// Latency: 1 cycle from request handshake to out_valid.
// Backpressure: single output register; in_ready = !out_valid || out_ready.
module rv32_instruction_encoder
  import rv32_isa_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [15:0]       word_count
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pack_word;
  logic        pack_bad;
  logic        req_fire;
  logic        rsp_fire;
  logic        load_word;
  logic        bad_fire;

  rv32_field_pack u_pack (
    .op   (in_op),
    .rd   (in_rd),
    .rs1  (in_rs1),
    .rs2  (in_rs2),
    .imm  (in_imm),
    .word (pack_word),
    .bad  (pack_bad)
  );

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign req_fire  = in_valid && in_ready;
  assign rsp_fire  = out_valid && out_ready;
  // Malformed requests are consumed but never occupy the output register.
  assign load_word = req_fire && !pack_bad;
  assign bad_fire  = req_fire && pack_bad;

  // Occupancy next state: a good load wins over a drain in the same cycle.
  always_comb begin
    state_next = state;
    if (load_word) begin
      state_next = ST_FULL;
    end else if (rsp_fire) begin
      state_next = ST_EMPTY;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output word holds until a good request replaces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_word <= '0;
    end else if (load_word) begin
      out_word <= pack_word;
    end
  end

  // Address and emitted-word count advance once per response handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_addr   <= BASE_ADDR;
      word_count <= '0;
    end else if (rsp_fire) begin
      out_addr   <= out_addr + ADDR_W'(4);
      word_count <= word_count + 16'd1;
    end
  end

  // Sticky error flag and saturating count of malformed requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (bad_fire) begin
      err <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_instruction_encoder.sv
// Directed bench for rv32_instruction_encoder with a narrow-address twin for wrap.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven directly by the scenario tasks.
module tb_rv32_instruction_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [11:0] out_addr;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] word_count;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_out_word;
  logic [3:0]  w_out_addr;
  logic        w_err;
  logic [7:0]  w_err_count;
  logic [15:0] w_word_count;

  int checks = 0;
  int errors = 0;

  rv32_instruction_encoder #(.ADDR_W(12), .BASE_ADDR(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err(err), .err_count(err_count), .word_count(word_count)
  );

  // Same stimulus, 4-bit address space so wraparound is reachable quickly.
  rv32_instruction_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_word(w_out_word),
    .out_addr(w_out_addr), .err(w_err), .err_count(w_err_count), .word_count(w_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [12:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL rst_out_word: got %h want 0", out_word); end
    checks++; if (out_addr !== 12'h000) begin errors++; $display("FAIL rst_out_addr: got %h want 000", out_addr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
  endtask

  task automatic test_addi();
    do_reset();
    out_ready = 1'b1;
    set_req(5'd16, 5'd1, 5'd0, 5'd0, 13'd5);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    checks++; if (out_word !== 32'h00500093) begin errors++; $display("FAIL addi_word: got %h want 00500093", out_word); end
    checks++; if (out_addr !== 12'h000) begin errors++; $display("FAIL addi_addr: got %h want 000", out_addr); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain_valid: got %b want 0", out_valid); end
    checks++; if (out_addr !== 12'h004) begin errors++; $display("FAIL addi_drain_addr: got %h want 004", out_addr); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL addi_word_count: got %0d want 1", word_count); end
  endtask

  task automatic test_rtype_shift();
    do_reset();
    out_ready = 1'b1;
    set_req(5'd6, 5'd3, 5'd1, 5'd2, 13'd0);
    tick();
    checks++; if (out_word !== 32'h402081B3) begin errors++; $display("FAIL sub_word: got %h want 402081b3", out_word); end
    checks++; if (out_addr !== 12'h000) begin errors++; $display("FAIL sub_addr: got %h want 000", out_addr); end
    // rs2 is ignored for shifts: a nonzero value must not leak into the word.
    set_req(5'd8, 5'd5, 5'd6, 5'd31, 13'd3);
    tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 32'h40335293) begin errors++; $display("FAIL srai_word: got %h want 40335293", out_word); end
    checks++; if (out_addr !== 12'h004) begin errors++; $display("FAIL srai_addr: got %h want 004", out_addr); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL srai_valid: got %b want 1", out_valid); end
    tick();
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL srai_word_count: got %0d want 2", word_count); end
  endtask

  task automatic test_branch();
    do_reset();
    out_ready = 1'b1;
    // rd is ignored for branches.
    set_req(5'd17, 5'd9, 5'd1, 5'd2, 13'd8);
    tick();
    checks++; if (out_word !== 32'h00208463) begin errors++; $display("FAIL beq_word: got %h want 00208463", out_word); end
    set_req(5'd22, 5'd0, 5'd1, 5'd2, 13'h1FFC);
    tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 32'hFE209EE3) begin errors++; $display("FAIL bne_word: got %h want fe209ee3", out_word); end
    checks++; if (out_addr !== 12'h004) begin errors++; $display("FAIL bne_addr: got %h want 004", out_addr); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    set_req(5'd16, 5'd2, 5'd0, 5'd0, 13'd1);
    tick();
    checks++; if (out_word !== 32'h00100113) begin errors++; $display("FAIL bp_first_word: got %h want 00100113", out_word); end
    set_req(5'd12, 5'd4, 5'd2, 5'd0, 13'h07F);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_word !== 32'h00100113) begin errors++; $display("FAIL bp_hold_word[%0d]: got %h want 00100113", i, out_word); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_addr !== 12'h000) begin errors++; $display("FAIL bp_addr[%0d]: got %h want 000", i, out_addr); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 32'h07F16213) begin errors++; $display("FAIL bp_next_word: got %h want 07f16213", out_word); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    checks++; if (out_addr !== 12'h004) begin errors++; $display("FAIL bp_next_addr: got %h want 004", out_addr); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL bp_word_count: got %0d want 1", word_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_final_valid: got %b want 0", out_valid); end
    checks++; if (out_addr !== 12'h008) begin errors++; $display("FAIL bp_final_addr: got %h want 008", out_addr); end
  endtask

  task automatic test_malformed();
    do_reset();
    out_ready = 1'b1;
    set_req(5'd23, 5'd1, 5'd1, 5'd1, 13'd0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bad_op_valid: got %b want 0", out_valid); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_op_err: got %b want 1", err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_op_count: got %0d want 1", err_count); end
    set_req(5'd10, 5'd1, 5'd2, 5'd0, 13'd32);
    tick();
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL bad_shamt_count: got %0d want 2", err_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bad_shamt_valid: got %b want 0", out_valid); end
    set_req(5'd17, 5'd0, 5'd1, 5'd2, 13'd3);
    tick();
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL bad_branch_count: got %0d want 3", err_count); end
    set_req(5'd16, 5'd1, 5'd0, 5'd0, 13'd5);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_after_bad_valid: got %b want 1", out_valid); end
    checks++; if (out_word !== 32'h00500093) begin errors++; $display("FAIL good_after_bad_word: got %h want 00500093", out_word); end
    checks++; if (out_addr !== 12'h000) begin errors++; $display("FAIL good_after_bad_addr: got %h want 000", out_addr); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    // Malformed request while the held word drains: register empties.
    set_req(5'd31, 5'd0, 5'd0, 5'd0, 13'd0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bad_drain_valid: got %b want 0", out_valid); end
    checks++; if (out_addr !== 12'h004) begin errors++; $display("FAIL bad_drain_addr: got %h want 004", out_addr); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL bad_drain_count: got %0d want 4", err_count); end
    // I-type immediate that does not fit in 12 bits signed.
    set_req(5'd16, 5'd1, 5'd0, 5'd0, 13'h0800);
    tick();
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL bad_itype_count: got %0d want 5", err_count); end
    // Negative immediate that does fit.
    set_req(5'd16, 5'd1, 5'd0, 5'd0, 13'h1FFF);
    tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 32'hFFF00093) begin errors++; $display("FAIL addi_neg_word: got %h want fff00093", out_word); end
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL addi_neg_count: got %0d want 5", err_count); end
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b1;
    set_req(5'd23, 5'd0, 5'd0, 5'd0, 13'd0);
    tick();
    set_req(5'd16, 5'd1, 5'd0, 5'd0, 13'd5);
    repeat (5) tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    checks++; if (out_addr !== 12'h010) begin errors++; $display("FAIL mid_pre_addr: got %h want 010", out_addr); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    checks++; if (out_addr !== 12'h000) begin errors++; $display("FAIL mid_addr: got %h want 000", out_addr); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL mid_word_count: got %0d want 0", word_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count: got %0d want 0", err_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    set_req(5'd16, 5'd1, 5'd0, 5'd0, 13'd5);
    repeat (4) tick();
    checks++; if (w_out_addr !== 4'hC) begin errors++; $display("FAIL wrap_4th_addr: got %h want c", w_out_addr); end
    tick();
    in_valid = 1'b0;
    checks++; if (w_out_addr !== 4'h0) begin errors++; $display("FAIL wrap_5th_addr: got %h want 0", w_out_addr); end
    checks++; if (w_word_count !== 16'd4) begin errors++; $display("FAIL wrap_word_count: got %0d want 4", w_word_count); end
    checks++; if (out_addr !== 12'h010) begin errors++; $display("FAIL wide_5th_addr: got %h want 010", out_addr); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    test_reset();
    test_addi();
    test_rtype_shift();
    test_branch();
    test_backpressure();
    test_malformed();
    test_reset_midstream();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
